// File: rtl/mandelbrot_pkg.sv
// Shared constants for the sequential Mandelbrot pixel engine.
// Optional Julia-set seeding is enabled with MANDELBROT_JULIA_EN.
package mandelbrot_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam int INT_BITS = 2;
   localparam int ESC_R2   = 4;

endpackage

// File: rtl/mandelbrot_step.sv
// One combinational z <- z^2 + c step with escape and overflow flags.
// Products are kept at full precision; next values at 2*WIDTH+1 bits.
module mandelbrot_step
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] zr,
   input  logic [WIDTH-1:0] zi,
   input  logic [WIDTH-1:0] cr,
   input  logic [WIDTH-1:0] ci,
   output logic [WIDTH-1:0] nzr,
   output logic [WIDTH-1:0] nzi,
   output logic             ovf,
   output logic             esc
);

   localparam int PW = 2 * WIDTH;
   localparam int MW = PW + 1;
   localparam int FB = WIDTH - INT_BITS;
   localparam logic signed [PW:0] LIM = MW'(ESC_R2) << (2 * FB);

   logic signed [PW-1:0] mrr, mii, mri;
   logic signed [PW:0]   mag, dre, dim, fre, fim;
   logic [WIDTH+1:0]     hr, hi;

   assign mrr = $signed(zr) * $signed(zr);
   assign mii = $signed(zi) * $signed(zi);
   assign mri = $signed(zr) * $signed(zi);

   assign mag = {mrr[PW-1], mrr} + {mii[PW-1], mii};
   assign dre = {mrr[PW-1], mrr} - {mii[PW-1], mii};
   assign dim = {mri, 1'b0};

   assign fre = (dre >>> FB)
              + $signed({{(WIDTH+1){cr[WIDTH-1]}}, cr});
   assign fim = (dim >>> FB)
              + $signed({{(WIDTH+1){ci[WIDTH-1]}}, ci});

   assign esc = (mag >= LIM);

   // in range only when every bit above the WIDTH-bit sign matches it
   assign hr  = fre[PW:WIDTH-1];
   assign hi  = fim[PW:WIDTH-1];
   assign ovf = ~(&hr | ~|hr) | ~(&hi | ~|hi);

   assign nzr = fre[WIDTH-1:0];
   assign nzi = fim[WIDTH-1:0];

endmodule

// File: rtl/mandelbrot_iter.sv
// Sequential Mandelbrot engine: one iteration per clock, valid/ready I/O.
// Define MANDELBROT_JULIA_EN to add in_julia/in_zr/in_zi seeding ports.
module mandelbrot_iter
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ITER_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_cr,
   input  logic [WIDTH-1:0]  in_ci,
   input  logic [ITER_W-1:0] in_max_iter,
`ifdef MANDELBROT_JULIA_EN
   input  logic              in_julia,
   input  logic [WIDTH-1:0]  in_zr,
   input  logic [WIDTH-1:0]  in_zi,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ITER_W-1:0] out_iter,
   output logic              out_escaped
);

   state_t            state;
   logic [WIDTH-1:0]  zr, zi, cr, ci;
   logic [WIDTH-1:0]  nzr, nzi, z0r, z0i;
   logic [ITER_W-1:0] n, m;
   logic              ovf, esc;

`ifdef MANDELBROT_JULIA_EN
   assign z0r = in_julia ? in_zr : '0;
   assign z0i = in_julia ? in_zi : '0;
`else
   assign z0r = '0;
   assign z0i = '0;
`endif

   mandelbrot_step #(.WIDTH(WIDTH)) u_step (
      .zr  (zr),
      .zi  (zi),
      .cr  (cr),
      .ci  (ci),
      .nzr (nzr),
      .nzi (nzi),
      .ovf (ovf),
      .esc (esc)
   );

   // gated by rst_n so the block never claims readiness while held in reset
   assign in_ready  = rst_n && (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         zr          <= '0;
         zi          <= '0;
         cr          <= '0;
         ci          <= '0;
         n           <= '0;
         m           <= '0;
         out_iter    <= '0;
         out_escaped <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  cr    <= in_cr;
                  ci    <= in_ci;
                  m     <= in_max_iter;
                  zr    <= z0r;
                  zi    <= z0i;
                  n     <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (esc) begin
                  out_iter    <= n;
                  out_escaped <= 1'b1;
                  state       <= ST_DONE;
               end else if (n == m) begin
                  out_iter    <= m;
                  out_escaped <= 1'b0;
                  state       <= ST_DONE;
               end else if (ovf) begin
                  out_iter    <= n + 1'b1;
                  out_escaped <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  zr <= nzr;
                  zi <= nzi;
                  n  <= n + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Directed-vector bench for mandelbrot_iter at WIDTH=8 (1.0 = 64).
// Table of hand-computed results plus hold and mid-run reset sequences.
module tb_mandelbrot_iter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_cr = '0;
   logic [7:0] in_ci = '0;
   logic [5:0] in_max_iter = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [5:0] out_iter;
   logic       out_escaped;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] cr;
      logic [7:0] ci;
      logic [5:0] m;
      int         iter;
      int         esc;
      int         lat;
   } vec_t;

   vec_t tv[11];

   mandelbrot_iter #(.WIDTH(8), .ITER_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_cr       (in_cr),
      .in_ci       (in_ci),
      .in_max_iter (in_max_iter),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_iter    (out_iter),
      .out_escaped (out_escaped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_wait(input logic [7:0] cr, input logic [7:0] ci,
                             input logic [5:0] m, output int lat);
      @(negedge clk);
      check("in_ready_before_accept", int'(in_ready), 1);
      in_cr       = cr;
      in_ci       = ci;
      in_max_iter = m;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) break;
      end
      if (!out_valid) check("timeout_out_valid", 0, 1);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("idle_after_take_valid", int'(out_valid), 0);
      check("idle_after_take_ready", int'(in_ready), 1);
   endtask

   initial begin
      int lat;
      tv[0]  = '{8'd0,    8'd0,    6'd10, 10, 0, 11};
      tv[1]  = '{8'h80,   8'd0,    6'd10, 1,  1, 2};
      tv[2]  = '{8'd64,   8'd0,    6'd10, 2,  1, 2};
      tv[3]  = '{8'h80,   8'd0,    6'd0,  0,  0, 1};
      tv[4]  = '{8'd0,    8'd64,   6'd10, 10, 0, 11};
      tv[5]  = '{8'hC0,   8'd0,    6'd5,  5,  0, 6};
      tv[6]  = '{8'd32,   8'd32,   6'd20, 5,  1, 5};
      tv[7]  = '{8'd0,    8'd127,  6'd10, 2,  1, 2};
      tv[8]  = '{8'd127,  8'd127,  6'd10, 1,  1, 2};
      tv[9]  = '{8'd64,   8'd0,    6'd1,  1,  0, 2};
      tv[10] = '{8'h80,   8'd0,    6'd1,  1,  1, 2};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_iter", int'(out_iter), 0);
      check("rst_out_escaped", int'(out_escaped), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", int'(in_ready), 1);

      for (int i = 0; i < 11; i++) begin
         start_wait(tv[i].cr, tv[i].ci, tv[i].m, lat);
         check($sformatf("v%0d_iter", i), int'(out_iter), tv[i].iter);
         check($sformatf("v%0d_esc", i), int'(out_escaped), tv[i].esc);
         check($sformatf("v%0d_lat", i), lat, tv[i].lat);
         release_out();
      end

      // hold DONE with out_ready low while a request is pulsed
      start_wait(8'h80, 8'd0, 6'd10, lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = (i == 2);
         in_cr = 8'd0;
         in_ci = 8'd0;
         in_max_iter = 6'd0;
         check("hold_valid", int'(out_valid), 1);
         check("hold_in_ready", int'(in_ready), 0);
         check("hold_iter", int'(out_iter), 1);
         check("hold_esc", int'(out_escaped), 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_out();
      repeat (3) begin
         @(posedge clk);
         #1;
         check("ignored_req_no_result", int'(out_valid), 0);
      end
      check("kept_iter_after_take", int'(out_iter), 1);

      // reset in the middle of a long run
      @(negedge clk);
      in_cr = 8'd0;
      in_ci = 8'd0;
      in_max_iter = 6'd63;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_in_ready", int'(in_ready), 0);
      check("midrst_iter", int'(out_iter), 0);
      check("midrst_esc", int'(out_escaped), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("midrst_no_pulse", int'(out_valid), 0);
      end
      start_wait(8'd64, 8'd0, 6'd10, lat);
      check("after_rst_iter", int'(out_iter), 2);
      check("after_rst_esc", int'(out_escaped), 1);
      check("after_rst_lat", lat, 2);
      release_out();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
